// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle MIPS main control FSM
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [2:0]         alu_op,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               ext_zero,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               branch_ne,
  output logic [1:0]         pc_source,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I,
    MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t state_q;

  // The branch decision is taken in the datapath; the flag is not needed here.
  logic unused_zero;
  assign unused_zero = zero;

  assign state = state_q;

  function automatic logic is_imm_alu(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) ||
           (op == OP_XORI) || (op == OP_SLTI) || (op == OP_SLTIU);
  endfunction

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI:  return 3'b011;
      OP_ORI:   return 3'b100;
      OP_XORI:  return 3'b101;
      OP_SLTI:  return 3'b110;
      OP_SLTIU: return 3'b111;
      default:  return 3'b000;
    endcase
  endfunction

  function automatic logic imm_zero_ext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

  // State register: steps the instruction, stalling memory states on mem_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH:     if (mem_ready) state_q <= DECODE;
        DECODE: begin
          if (opcode == OP_RTYPE)                        state_q <= EXEC_R;
          else if (opcode == OP_LW || opcode == OP_SW)   state_q <= MEM_ADDR;
          else if (opcode == OP_BEQ || opcode == OP_BNE) state_q <= BRANCH;
          else if (opcode == OP_J)                       state_q <= JUMP;
          else if (is_imm_alu(opcode))                   state_q <= EXEC_I;
          else                                           state_q <= FETCH;
        end
        EXEC_R:    state_q <= WB_R;
        EXEC_I:    state_q <= WB_I;
        MEM_ADDR:  state_q <= (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
        MEM_READ:  if (mem_ready) state_q <= MEM_WB;
        MEM_WRITE: if (mem_ready) state_q <= FETCH;
        default:   state_q <= FETCH;
      endcase
    end
  end

  // Output decode: Moore per state, with mem_ready gating the fetch load and store completion.
  always_comb begin
    alu_op        = 3'b000;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ext_zero      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        if (!(opcode == OP_RTYPE || opcode == OP_LW || opcode == OP_SW ||
              opcode == OP_BEQ || opcode == OP_BNE || opcode == OP_J ||
              is_imm_alu(opcode))) begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
        end
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      WB_R: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = imm_alu_op(opcode);
        ext_zero  = imm_zero_ext(opcode);
      end
      WB_I: begin
        alu_op     = imm_alu_op(opcode);
        ext_zero   = imm_zero_ext(opcode);
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = opcode[0];
        instr_done    = 1'b1;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - randomized self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_zero, pc_write, pc_write_cond, branch_ne;
  logic [1:0] pc_source;
  logic       i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, instr_done, illegal_op;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // Observed control word, in the same field order as mk() below.
  logic [20:0] obs;
  assign obs = {alu_op, alu_src_a, alu_src_b, ext_zero, pc_write, pc_write_cond,
                branch_ne, pc_source, i_or_d, mem_read, mem_write, ir_write,
                reg_dst, mem_to_reg, reg_write, instr_done, illegal_op};

  // Enable bits: pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, instr_done, illegal_op
  localparam logic [20:0] EN_MASK = 21'b000_0_00_0_1_1_0_00_0_1_1_1_0_0_1_1_1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [20:0] mk(
      input logic [2:0] op, input logic a, input logic [1:0] b, input logic ez,
      input logic pw, input logic pwc, input logic bne, input logic [1:0] ps,
      input logic iord, input logic mr, input logic mw, input logic irw,
      input logic rd, input logic m2r, input logic rw, input logic done, input logic ill);
    return {op, a, b, ez, pw, pwc, bne, ps, iord, mr, mw, irw, rd, m2r, rw, done, ill};
  endfunction

  logic [5:0] legal_ops [12] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02,
                                 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B};

  function automatic bit is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: the ALU operation and extension mode each immediate instruction needs.
  function automatic logic [3:0] imm_info(input logic [5:0] op);
    case (op)
      6'h08: return {3'd0, 1'b0};  // addi
      6'h0C: return {3'd3, 1'b1};  // andi
      6'h0D: return {3'd4, 1'b1};  // ori
      6'h0E: return {3'd5, 1'b1};  // xori
      6'h0A: return {3'd6, 1'b0};  // slti
      default: return {3'd7, 1'b0}; // sltiu
    endcase
  endfunction

  // One clock: drive mem_ready, check the control word mid-cycle, return just after the next edge.
  task automatic cyc(input logic rdy, input logic [20:0] exp, input string tag);
    mem_ready = rdy;
    @(negedge clk);
    check(tag, {11'd0, obs}, {11'd0, exp});
    check("mem_rd_wr_excl", {31'd0, mem_read & mem_write}, 32'd0);
    check("rw_pw_excl", {31'd0, reg_write & pc_write}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom);
  endfunction

  task automatic do_fetch(input int stalls);
    opcode = 6'($urandom);
    for (int i = 0; i < stalls; i++)
      cyc(1'b0, mk(0,0,2'b01,0, 0,0,0,0, 0,1,0,0, 0,0,0,0,0), "fetch_stall");
    cyc(1'b1, mk(0,0,2'b01,0, 1,0,0,0, 0,1,0,1, 0,0,0,0,0), "fetch");
  endtask

  // Full instruction from FETCH back to FETCH with the given stall counts.
  task automatic run_instr(input logic [5:0] op, input int f_stalls, input int m_stalls);
    logic [3:0] ii;
    do_fetch(f_stalls);
    opcode = op;
    if (!is_legal(op)) begin
      cyc(rnd_bit(), mk(0,0,2'b11,0, 0,0,0,0, 0,0,0,0, 0,0,0,1,1), "decode_illegal");
      return;
    end
    cyc(rnd_bit(), mk(0,0,2'b11,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0), "decode");
    if (op == 6'h00) begin
      cyc(rnd_bit(), mk(3'd2,1,2'b00,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0), "exec_r");
      cyc(rnd_bit(), mk(0,0,2'b00,0, 0,0,0,0, 0,0,0,0, 1,0,1,1,0), "wb_r");
    end else if (op == 6'h23) begin
      cyc(rnd_bit(), mk(0,1,2'b10,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0), "mem_addr_lw");
      for (int i = 0; i < m_stalls; i++)
        cyc(1'b0, mk(0,0,2'b00,0, 0,0,0,0, 1,1,0,0, 0,0,0,0,0), "mem_read_stall");
      cyc(1'b1, mk(0,0,2'b00,0, 0,0,0,0, 1,1,0,0, 0,0,0,0,0), "mem_read");
      cyc(rnd_bit(), mk(0,0,2'b00,0, 0,0,0,0, 0,0,0,0, 0,1,1,1,0), "mem_wb");
    end else if (op == 6'h2B) begin
      cyc(rnd_bit(), mk(0,1,2'b10,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0), "mem_addr_sw");
      for (int i = 0; i < m_stalls; i++)
        cyc(1'b0, mk(0,0,2'b00,0, 0,0,0,0, 1,0,1,0, 0,0,0,0,0), "mem_write_stall");
      cyc(1'b1, mk(0,0,2'b00,0, 0,0,0,0, 1,0,1,0, 0,0,0,1,0), "mem_write");
    end else if (op == 6'h04 || op == 6'h05) begin
      cyc(rnd_bit(), mk(3'd1,1,2'b00,0, 0,1,op[0],2'b01, 0,0,0,0, 0,0,0,1,0), "branch");
    end else if (op == 6'h02) begin
      cyc(rnd_bit(), mk(0,0,2'b00,0, 1,0,0,2'b10, 0,0,0,0, 0,0,0,1,0), "jump");
    end else begin
      ii = imm_info(op);
      cyc(rnd_bit(), mk(ii[3:1],1,2'b10,ii[0], 0,0,0,0, 0,0,0,0, 0,0,0,0,0), "exec_i");
      cyc(rnd_bit(), mk(ii[3:1],0,2'b00,ii[0], 0,0,0,0, 0,0,0,0, 0,0,1,1,0), "wb_i");
    end
  endtask

  initial begin
    logic [5:0] op;
    reset = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_enables", {11'd0, obs & EN_MASK}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed: R, lw with stalls, ori, slti, bne, beq, illegal, sw, j
    run_instr(6'h00, 0, 0);
    run_instr(6'h23, 2, 3);
    run_instr(6'h0D, 0, 0);
    run_instr(6'h0A, 0, 0);
    run_instr(6'h05, 0, 0);
    run_instr(6'h04, 1, 0);
    run_instr(6'h3F, 0, 0);
    run_instr(6'h2B, 0, 2);
    run_instr(6'h02, 0, 0);

    // Reset held three cycles in the middle of an R-type instruction
    do_fetch(0);
    opcode = 6'h00;
    cyc(1'b1, mk(0,0,2'b11,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0), "decode");
    cyc(1'b1, mk(3'd2,1,2'b00,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0), "exec_r");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1;
      @(negedge clk);
      check("reset_mid_enables", {11'd0, obs & EN_MASK}, 32'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    run_instr(6'h00, 0, 0);

    // Randomized instruction mix including illegal opcodes
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 11)];
      end
      zero = rnd_bit();
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
